// File: rtl/fetch_instr_queue.sv
`default_nettype none
// ============================================================================
// fetch_instr_queue: splits 2-slot fetch packets into a DEPTH-entry circular
// instruction queue feeding the decoder one instruction per cycle.
// Revision: 1.0
// ============================================================================
module fetch_instr_queue #(
  parameter int DEPTH       = 8,
  parameter int VADDR_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_fetch_valid,
  output logic                       o_fetch_ready,
  input  logic [VADDR_WIDTH-1:0]     i_fetch_pc,
  input  logic [63:0]                i_fetch_data,
  input  logic [1:0]                 i_fetch_mask,
  output logic                       o_instr_valid,
  input  logic                       i_decode_ready,
  output logic [31:0]                o_instr,
  output logic [VADDR_WIDTH-1:0]     o_pc,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]       c_ready_max = CNT_W'(DEPTH - 2);
  localparam logic [VADDR_WIDTH-1:0] c_slot_step = VADDR_WIDTH'(4);

  logic [31:0]            r_instr [DEPTH];
  logic [VADDR_WIDTH-1:0] r_pc    [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;

  logic                   w_enq;
  logic                   w_deq;
  logic                   w_two_slots;
  logic                   w_any_slot;
  logic [CNT_W-1:0]       w_n_enq;
  logic [CNT_W-1:0]       w_n_deq;
  logic [PTR_W-1:0]       w_wr_ptr_p1;
  logic [31:0]            w_first_instr;
  logic [VADDR_WIDTH-1:0] w_first_pc;
  logic [VADDR_WIDTH-1:0] w_slot1_pc;

  // Ready only looks at registered occupancy so decode never feeds back into fetch.
  assign o_fetch_ready = (r_count <= c_ready_max);
  assign o_instr_valid = (r_count != '0);
  assign o_count       = r_count;
  assign o_instr       = r_instr[r_rd_ptr];
  assign o_pc          = r_pc[r_rd_ptr];

  assign w_enq       = i_fetch_valid & o_fetch_ready & ~i_flush;
  assign w_deq       = o_instr_valid & i_decode_ready & ~i_flush;
  assign w_two_slots = i_fetch_mask[0] & i_fetch_mask[1];
  assign w_any_slot  = i_fetch_mask[0] | i_fetch_mask[1];
  assign w_wr_ptr_p1 = r_wr_ptr + PTR_W'(1);
  assign w_slot1_pc  = i_fetch_pc + c_slot_step;

  // The first written entry is slot 0 if present, otherwise slot 1.
  assign w_first_instr = i_fetch_mask[0] ? i_fetch_data[31:0] : i_fetch_data[63:32];
  assign w_first_pc    = i_fetch_mask[0] ? i_fetch_pc : w_slot1_pc;

  always_comb begin
    w_n_enq = '0;
    if (w_enq) begin
      w_n_enq = CNT_W'(i_fetch_mask[0]) + CNT_W'(i_fetch_mask[1]);
    end
    w_n_deq = CNT_W'(w_deq);
  end

  // Storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge i_clk) begin
    if (w_enq && w_any_slot) begin
      r_instr[r_wr_ptr] <= w_first_instr;
      r_pc[r_wr_ptr]    <= w_first_pc;
      if (w_two_slots) begin
        r_instr[w_wr_ptr_p1] <= i_fetch_data[63:32];
        r_pc[w_wr_ptr_p1]    <= w_slot1_pc;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_enq);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_deq);
      r_count  <= r_count + w_n_enq - w_n_deq;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_instr_queue.sv
`default_nettype none
// Table-driven bench for fetch_instr_queue with a FIFO scoreboard of expected
// {instr, pc} entries.
module tb_fetch_instr_queue;

  localparam int DEPTH = 8;
  localparam int VW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          fetch_valid = 1'b0;
  logic          fetch_ready;
  logic [VW-1:0] fetch_pc = '0;
  logic [63:0]   fetch_data = '0;
  logic [1:0]    fetch_mask = '0;
  logic          instr_valid;
  logic          decode_ready = 1'b0;
  logic [31:0]   instr;
  logic [VW-1:0] pc;
  logic [3:0]    count;

  fetch_instr_queue #(.DEPTH(DEPTH), .VADDR_WIDTH(VW)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_fetch_valid  (fetch_valid),
    .o_fetch_ready  (fetch_ready),
    .i_fetch_pc     (fetch_pc),
    .i_fetch_data   (fetch_data),
    .i_fetch_mask   (fetch_mask),
    .o_instr_valid  (instr_valid),
    .i_decode_ready (decode_ready),
    .o_instr        (instr),
    .o_pc           (pc),
    .o_count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          flush;
    logic          fv;
    logic [VW-1:0] pc;
    logic [63:0]   data;
    logic [1:0]    mask;
    logic          dr;
    int            exp_cnt;   // occupancy after this vector's edge, -1 = skip
  } vec_t;

  typedef struct {
    logic [31:0]   instr;
    logic [VW-1:0] pc;
  } entry_t;

  entry_t sb[$];
  vec_t   vecs[$];
  int     tests  = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic fv, input logic [VW-1:0] p,
                              input logic [63:0] d, input logic [1:0] m, input logic dr,
                              input int ec);
    vec_t v;
    v.flush = fl; v.fv = fv; v.pc = p; v.data = d; v.mask = m; v.dr = dr; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic logic [63:0] pk(input logic [VW-1:0] p);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = 32'hA000_0000 ^ p;
    hi = 32'hB000_0000 ^ (p + 32'd4);
    return {hi, lo};
  endfunction

  task automatic step(input vec_t v);
    bit deq;
    bit enq;
    entry_t e;
    flush = v.flush; fetch_valid = v.fv; fetch_pc = v.pc;
    fetch_data = v.data; fetch_mask = v.mask; decode_ready = v.dr;
    #1;
    chk("count", 64'(count), 64'(sb.size()));
    chk("fetch_ready", 64'(fetch_ready), 64'(sb.size() <= DEPTH - 2));
    chk("instr_valid", 64'(instr_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("instr", 64'(instr), 64'(sb[0].instr));
      chk("pc", 64'(pc), 64'(sb[0].pc));
    end
    deq = (sb.size() != 0) && v.dr;
    enq = v.fv && (sb.size() <= DEPTH - 2);
    if (v.flush) begin
      sb.delete();
    end else begin
      if (deq) void'(sb.pop_front());
      if (enq && v.mask[0]) begin
        e.instr = v.data[31:0];  e.pc = v.pc;         sb.push_back(e);
      end
      if (enq && v.mask[1]) begin
        e.instr = v.data[63:32]; e.pc = v.pc + 32'd4; sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (v.exp_cnt >= 0) chk("exp_count", 64'(count), 64'(v.exp_cnt));
  endtask

  task automatic idle(input logic dr, input int ec);
    step(mk(1'b0, 1'b0, '0, '0, 2'b00, dr, ec));
  endtask

  task automatic pkt(input logic [VW-1:0] p, input logic [1:0] m, input logic dr, input int ec);
    step(mk(1'b0, 1'b1, p, pk(p), m, dr, ec));
  endtask

  initial begin
    // Reset then single full packet, drained in order.
    vecs.push_back(mk(0, 1, 32'h1000, {32'h00500093, 32'h00100513}, 2'b11, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 1, 0));
    // Slot-1-only, then empty mask.
    vecs.push_back(mk(0, 1, 32'h2000, {32'h0000006F, 32'hDEADBEEF}, 2'b10, 0, 1));
    vecs.push_back(mk(0, 1, 32'h2100, {32'h11111111, 32'h22222222}, 2'b00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 1, 0));
    // Fill with decoder stalled, throttle at the full boundary.
    vecs.push_back(mk(0, 1, 32'h5000, pk(32'h5000), 2'b11, 0, 2));
    vecs.push_back(mk(0, 1, 32'h5008, pk(32'h5008), 2'b11, 0, 4));
    vecs.push_back(mk(0, 1, 32'h5010, pk(32'h5010), 2'b11, 0, 6));
    vecs.push_back(mk(0, 1, 32'h5018, pk(32'h5018), 2'b11, 0, 8));
    vecs.push_back(mk(0, 1, 32'h5020, pk(32'h5020), 2'b11, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 1, 7));
    vecs.push_back(mk(0, 1, 32'h5020, pk(32'h5020), 2'b11, 1, 6));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 0, 6));
    for (int i = 5; i >= 0; i--) vecs.push_back(mk(0, 0, 0, 0, 2'b00, 1, i));

    #12;
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Walk pointers to DEPTH-1, then a two-slot write that wraps to entry 0.
    pkt(32'h6000, 2'b11, 0, 2);
    pkt(32'h6008, 2'b11, 1, 3);
    idle(1, 2); idle(1, 1); idle(1, 0);
    pkt(32'h3000, 2'b11, 0, 2);
    idle(1, 1); idle(1, 0);

    // Flush with simultaneous enqueue and dequeue, then a redirected packet.
    pkt(32'h7000, 2'b11, 0, 2);
    pkt(32'h7008, 2'b11, 0, 4);
    pkt(32'h7010, 2'b01, 0, 5);
    step(mk(1, 1, 32'h7800, pk(32'h7800), 2'b11, 1, 0));
    pkt(32'h4000, 2'b11, 0, 2);
    idle(1, 1); idle(1, 0);

    // Asynchronous reset between edges with four entries queued.
    pkt(32'h8000, 2'b11, 0, 2);
    pkt(32'h8008, 2'b11, 0, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ready", 64'(fetch_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    pkt(32'h9000, 2'b11, 0, 2);
    idle(1, 1); idle(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_instr_queue.md
# fetch_instr_queue

Instruction queue between fetch and `instr_field_decoder`. It accepts 64-bit fetch packets of up to two 32-bit instructions, with a slot mask and packet PC, and stores each valid slot as a separate entry. It presents one `aligned_instr_t` plus its PC per cycle to the decoder under a valid/ready handshake. It decouples fetch stalls from decode stalls and drops all in-flight instructions on a pipeline flush.

## Interface
- `DEPTH`, default 8: entries, one instruction each; power of two, ≥ 4.
- `VADDR_WIDTH`, default 32: PC width.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_flush`  in  1  discard all entries and any packet offered this cycle.
- `i_fetch_valid`  in  1  fetch packet valid.
- `o_fetch_ready`  out  1  queue can accept a full packet this cycle.
- `i_fetch_pc`  in  VADDR_WIDTH  PC of slot 0; 8-byte aligned.
- `i_fetch_data`  in  64  slot 0 = [31:0], slot 1 = [63:32].
- `i_fetch_mask`  in  2  per-slot valid; bit n = slot n.
- `o_instr_valid`  out  1  head entry valid.
- `i_decode_ready`  in  1  decoder consumes head this cycle.
- `o_instr`  out  32  head instruction (`aligned_instr_t`).
- `o_pc`  out  VADDR_WIDTH  head PC.
- `o_count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH-entry circular buffer of {instr, pc}, head pointer `rd_ptr` and tail pointer `wr_ptr`, each $clog2(DEPTH) bits and wrapping modulo DEPTH. An occupancy counter `count` distinguishes full from empty.
- Enqueue fires when `i_fetch_valid & o_fetch_ready & ~i_flush`. Valid slots are written in slot order at consecutive tail positions:
  - mask 2'b11: slot0 goes to `wr_ptr` with pc = `i_fetch_pc`; slot1 goes to `wr_ptr+1` with pc = `i_fetch_pc+4`. `wr_ptr` advances by 2.
  - mask 2'b01: slot0 only, pc = `i_fetch_pc`; `wr_ptr` advances by 1.
  - mask 2'b10: slot1 only, written to `wr_ptr` with pc = `i_fetch_pc+4`; `wr_ptr` advances by 1.
  - mask 2'b00: the packet is accepted and discarded; no state change.
- PC arithmetic wraps modulo 2^VADDR_WIDTH.
- Dequeue fires when `o_instr_valid & i_decode_ready & ~i_flush`. `rd_ptr` advances by 1.
- Next `count` = `count` + number of enqueued slots (0–2) − dequeue (0/1). Enqueue and dequeue in the same cycle are both honoured.
- `o_fetch_ready` = (DEPTH − `count`) ≥ 2. It depends only on registered `count` and never on `i_decode_ready`, so there is no combinational path from decode to fetch.
- `o_instr_valid` = (`count` != 0). `o_instr`/`o_pc` = storage[`rd_ptr`], read combinationally from the registers. When `o_instr_valid` = 0 these outputs are don't-care; the bench must not check them.
- Flush: next cycle `count`=0, `rd_ptr`=`wr_ptr`=0. Flush overrides any enqueue or dequeue in the same cycle. Storage contents are not cleared.
- Reset: same state as flush. Outputs during and immediately after reset: `o_instr_valid`=0, `o_count`=0, `o_fetch_ready`=1.

## Timing
- Enqueue-to-visible latency is 1 cycle; there is no bypass. An instruction enqueued at edge N is on `o_instr` with `o_instr_valid`=1 in the cycle after edge N.
- Sustained throughput is 1 instruction/cycle out and up to 2 in. With a continuously ready decoder and full packets, the queue fills and fetch is throttled by `o_fetch_ready`.
- Full boundary: with `count` = DEPTH−1, `o_fetch_ready`=0 even if a dequeue is occurring. It stays 0 until `count` ≤ DEPTH−2 at a clock edge.
- Empty boundary: with `count`=0, `i_decode_ready` is ignored and an enqueue that cycle does not produce a same-cycle output.
- Wrap-around: a two-slot write with `wr_ptr` = DEPTH−1 writes entries DEPTH−1 and 0.
- Reset asserted mid-operation clears the state asynchronously. The first enqueue is possible on the first rising edge after `i_rst` deasserts.
- `i_flush` takes effect on the same edge it is sampled. The cycle after flush shows `o_instr_valid`=0, and fetch can enqueue the redirected packet in that same cycle.

## Test plan
- **Reset, then single packet:** reset, then packet pc=0x1000, data={0x00500093, 0x00100513}, mask=2'b11.
  - Next cycle: o_instr=0x00100513, o_pc=0x1000, o_count=2.
  - With decoder ready: the following cycle shows o_instr=0x00500093, o_pc=0x1004; then o_instr_valid=0.
- **Slot-1-only packet:** pc=0x2000, mask=2'b10, data[63:32]=0x0000006F → o_instr=0x0000006F, o_pc=0x2004, o_count=1. Mask 2'b00 → o_count unchanged.
- **Fill with decoder stalled (DEPTH=8):** send four full packets with i_decode_ready=0.
  - o_fetch_ready drops when o_count=7 or 8; here o_count=8, o_fetch_ready=0.
  - Raise i_decode_ready for 2 cycles → o_count=6, o_fetch_ready=1.
  - PCs come out strictly in program order.
- **Wrap-around:** after 7 enqueues and 7 dequeues (rd_ptr=wr_ptr=7), send packet pc=0x3000, mask=2'b11 → outputs 0x3000 then 0x3004 in order, o_count back to 0.
- **Flush with simultaneous enqueue and dequeue:** with o_count=5, assert i_flush together with a valid packet and i_decode_ready=1.
  - Next cycle: o_count=0, o_instr_valid=0.
  - A packet pc=0x4000 sent that cycle appears at the output the cycle after.
- **Asynchronous reset mid-stream:** assert i_rst between clock edges while o_count=4 → o_instr_valid=0 and o_count=0 immediately, without waiting for a clock edge; o_fetch_ready=1.
